sprite_write_arbiter: RTL and testbench

Arbitrates and sequences all writes into the back half of the double-buffered 24x45 frame store. Up to NUM_REQ sprite or tile drawers request single-pixel writes, and the block grants one per cycle in round-robin order. It drops transparent and out-of-range pixels and clears the back buffer at frame start. It swaps front and back buffers on the vertical-sync falling edge once every drawer has reported done. It sits between the drawing engines and the frame-store write port, and drives the buffer-select line the scan-out side uses to choose its read buffer.

---
 rtl/sprite_write_arbiter.sv | 258 +++++++++++++++++++++++++
 tb/tb_sprite_write_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_write_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_write_arbiter
//
// Sequences every write into the back half of the double-buffered frame store.
// Drawing engines raise single-pixel write requests; one is granted per cycle
// in round-robin order. Transparent and out-of-range pixels are granted but
// not written. Front and back buffers swap on the VS falling edge once every
// drawer has reported done for the frame.
//
// Build option:
//   ARB_CLEAR_EN  defined   -> a CLEAR state fills the back buffer with BG_PIX
//                              after reset and after every swap.
//                 undefined -> no CLEAR state or counter; reset and swap go
//                              straight to DRAW.
//
// Ports:
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   VS           vertical sync, active-low
//   req          per-requester write request (level)
//   done         per-requester frame-drawing-finished (level)
//   wr_x, wr_y   packed 10-bit coordinates, requester i at [10i+9:10i]
//   wr_pix       packed PIX_W-bit pixel codes
//   gnt          one-hot grant (combinational)
//   fb_we        back-buffer write enable (registered)
//   fb_addr      back-buffer address x + y*FB_W (registered)
//   fb_wdata     back-buffer write data (registered)
//   buf_sel      0: top buffer is front, 1: bottom buffer is front
//   frame_start  one-cycle pulse coinciding with the swap
//   overrun      sticky: VS fell before the frame was complete
// -----------------------------------------------------------------------------
module sprite_write_arbiter #(
    parameter int               NUM_REQ     = 4,
    parameter int               FB_W        = 24,
    parameter int               FB_H        = 45,
    parameter int               PIX_W       = 5,
    parameter logic [PIX_W-1:0] TRANSPARENT = 5'h15,
    parameter logic [PIX_W-1:0] BG_PIX      = 5'h00
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     VS,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       done,
    input  logic [NUM_REQ*10-1:0]    wr_x,
    input  logic [NUM_REQ*10-1:0]    wr_y,
    input  logic [NUM_REQ*PIX_W-1:0] wr_pix,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     fb_we,
    output logic [10:0]              fb_addr,
    output logic [PIX_W-1:0]         fb_wdata,
    output logic                     buf_sel,
    output logic                     frame_start,
    output logic                     overrun
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW      = PTR_W + 1;
    localparam int FB_SIZE = FB_W * FB_H;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_DRAW    = 2'd1,
        ST_WAIT_VS = 2'd2,
        ST_SWAP    = 2'd3
    } state_e;

`ifdef ARB_CLEAR_EN
    localparam state_e ST_INIT = ST_CLEAR;
`else
    localparam state_e ST_INIT = ST_DRAW;
`endif

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  done_mask_q, done_mask_d;
    logic                vs_q;
    logic                fb_we_q, fb_we_d;
    logic [10:0]         fb_addr_q, fb_addr_d;
    logic [PIX_W-1:0]    fb_wdata_q, fb_wdata_d;
    logic                buf_sel_q, buf_sel_d;
    logic                frame_start_q, frame_start_d;
    logic                overrun_q, overrun_d;
`ifdef ARB_CLEAR_EN
    logic [10:0]         clr_cnt_q, clr_cnt_d;
`endif

    logic                gnt_any_s;
    logic [PTR_W-1:0]    gnt_idx_s;
    logic [CW-1:0]       cand_s;
    logic [CW-1:0]       nxt_ptr_s;
    logic [9:0]          sel_x_s;
    logic [9:0]          sel_y_s;
    logic [PIX_W-1:0]    sel_pix_s;
    logic                pix_ok_s;
    logic                vs_fall_s;

    assign vs_fall_s = vs_q & ~VS;

    // Round-robin search: first asserted request at or after rr_ptr.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = '0;
        cand_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, rr_ptr_q} + CW'(k);
            cand_s = (cand_s >= CW'(NUM_REQ)) ? (cand_s - CW'(NUM_REQ)) : cand_s;
            if (!gnt_any_s && req[cand_s[PTR_W-1:0]]) begin
                gnt_any_s = 1'b1;
                gnt_idx_s = cand_s[PTR_W-1:0];
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

    // Pointer that follows the winner, and the winner's coordinates/pixel.
    always_comb begin
        nxt_ptr_s = {1'b0, gnt_idx_s} + CW'(1);
        sel_x_s   = wr_x[32'(gnt_idx_s) * 10 +: 10];
        sel_y_s   = wr_y[32'(gnt_idx_s) * 10 +: 10];
        sel_pix_s = wr_pix[32'(gnt_idx_s) * PIX_W +: PIX_W];
        pix_ok_s  = (sel_pix_s != TRANSPARENT) &&
                    (32'(sel_x_s) < 32'(FB_W)) &&
                    (32'(sel_y_s) < 32'(FB_H));
    end

    // Grant is only visible while drawing and out of reset.
    always_comb begin
        gnt = '0;
        if ((state_q == ST_DRAW) && gnt_any_s && !Reset) begin
            gnt[gnt_idx_s] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

    // Next-state, write-port and status logic.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        done_mask_d   = done_mask_q;
        fb_we_d       = 1'b0;
        fb_addr_d     = fb_addr_q;
        fb_wdata_d    = fb_wdata_q;
        buf_sel_d     = buf_sel_q;
        frame_start_d = 1'b0;
        overrun_d     = overrun_q;
`ifdef ARB_CLEAR_EN
        clr_cnt_d     = clr_cnt_q;
`endif
        case (state_q)
            ST_CLEAR: begin
`ifdef ARB_CLEAR_EN
                fb_we_d     = 1'b1;
                fb_addr_d   = clr_cnt_q;
                fb_wdata_d  = BG_PIX;
                done_mask_d = '0;
                overrun_d   = overrun_q | vs_fall_s;
                if (clr_cnt_q == 11'(FB_SIZE - 1)) begin
                    clr_cnt_d = 11'd0;
                    state_d   = ST_DRAW;
                end else begin
                    clr_cnt_d = clr_cnt_q + 11'd1;
                end
`else
                state_d = ST_DRAW;
`endif
            end
            ST_DRAW: begin
                // A VS edge while still drawing is too early: flag it, no swap.
                overrun_d   = overrun_q | vs_fall_s;
                done_mask_d = done_mask_q | done;
                if (gnt_any_s) begin
                    rr_ptr_d = (nxt_ptr_s >= CW'(NUM_REQ)) ? '0 : nxt_ptr_s[PTR_W-1:0];
                    if (pix_ok_s) begin
                        fb_we_d    = 1'b1;
                        fb_addr_d  = 11'(32'(sel_x_s) + 32'(sel_y_s) * 32'(FB_W));
                        fb_wdata_d = sel_pix_s;
                    end else begin
                        fb_we_d = 1'b0;
                    end
                end else begin
                    rr_ptr_d = rr_ptr_q;
                end
                if (&done_mask_d) begin
                    state_d = ST_WAIT_VS;
                end else begin
                    state_d = ST_DRAW;
                end
            end
            ST_WAIT_VS: begin
                // buf_sel and frame_start are registered on entry to SWAP so
                // they change in the same cycle the SWAP state is visible.
                if (vs_fall_s) begin
                    state_d       = ST_SWAP;
                    buf_sel_d     = ~buf_sel_q;
                    frame_start_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_VS;
                end
            end
            ST_SWAP: begin
                done_mask_d = '0;
                state_d     = ST_INIT;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_INIT;
            rr_ptr_q      <= '0;
            done_mask_q   <= '0;
            vs_q          <= 1'b1;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= 11'd0;
            fb_wdata_q    <= '0;
            buf_sel_q     <= 1'b0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            done_mask_q   <= done_mask_d;
            vs_q          <= VS;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_wdata_q    <= fb_wdata_d;
            buf_sel_q     <= buf_sel_d;
            frame_start_q <= frame_start_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef ARB_CLEAR_EN
    // Clear address counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clr_cnt_q <= 11'd0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end
`endif

    assign fb_we       = fb_we_q;
    assign fb_addr     = fb_addr_q;
    assign fb_wdata    = fb_wdata_q;
    assign buf_sel     = buf_sel_q;
    assign frame_start = frame_start_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_sprite_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sprite_write_arbiter
//
// Directed bench for sprite_write_arbiter. Expected values are hand-computed
// constants. Works for either setting of ARB_CLEAR_EN.
// Requester i sits at x=i+1, y=i+2 with pixel i+1, so its address is
// 49, 74, 99, 124 for i = 0..3.
// -----------------------------------------------------------------------------
module tb_sprite_write_arbiter;

    logic        Clk;
    logic        Reset;
    logic        VS;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [39:0] wr_x;
    logic [39:0] wr_y;
    logic [19:0] wr_pix;
    logic [3:0]  gnt;
    logic        fb_we;
    logic [10:0] fb_addr;
    logic [4:0]  fb_wdata;
    logic        buf_sel;
    logic        frame_start;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    int exp_addr [4] = '{49, 74, 99, 124};
    int exp_pix  [4] = '{1, 2, 3, 4};
    int exp_ptr;

    sprite_write_arbiter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .VS          (VS),
        .req         (req),
        .done        (done),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_pix      (wr_pix),
        .gnt         (gnt),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_wdata    (fb_wdata),
        .buf_sel     (buf_sel),
        .frame_start (frame_start),
        .overrun     (overrun)
    );

    // Free-running 10 ns clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req2(input logic [9:0] x, input logic [9:0] y, input logic [4:0] p);
        wr_x[29:20]   = x;
        wr_y[29:20]   = y;
        wr_pix[14:10] = p;
    endtask

    task automatic check_write(input string tag, input int idx);
        check_val({tag, "_we"},   32'(fb_we),    32'd1);
        check_val({tag, "_addr"}, 32'(fb_addr),  32'(exp_addr[idx]));
        check_val({tag, "_data"}, 32'(fb_wdata), 32'(exp_pix[idx]));
    endtask

    initial begin
        Reset  = 1'b1;
        VS     = 1'b1;
        req    = 4'hF;
        done   = 4'h0;
        wr_x   = {10'd4, 10'd3, 10'd2, 10'd1};
        wr_y   = {10'd5, 10'd4, 10'd3, 10'd2};
        wr_pix = {5'd4, 5'd3, 5'd2, 5'd1};
        exp_ptr = 0;

        // Reset state, with requests already pending.
        tick(); tick(); tick();
        check_val("rst_gnt",   32'(gnt),         32'd0);
        check_val("rst_we",    32'(fb_we),       32'd0);
        check_val("rst_addr",  32'(fb_addr),     32'd0);
        check_val("rst_data",  32'(fb_wdata),    32'd0);
        check_val("rst_bsel",  32'(buf_sel),     32'd0);
        check_val("rst_fs",    32'(frame_start), 32'd0);
        check_val("rst_ovr",   32'(overrun),     32'd0);

        Reset = 1'b0;
        req   = 4'b0001;
`ifdef ARB_CLEAR_EN
        #1;
        check_val("clr_gnt0", 32'(gnt), 32'd0);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 1080; i++) begin
                tick();
                if (!(fb_we === 1'b1 && fb_addr === 11'(i) && fb_wdata === 5'd0 && gnt === 4'd0))
                    bad++;
            end
            check_val("clr_seq_bad", 32'(bad), 32'd0);
        end
`endif
        // First grant: cycle 1 after reset without clear, right after clear otherwise.
        #1;
        check_val("first_gnt", 32'(gnt), 32'b0001);
        tick();
        check_write("first_wr", 0);
        exp_ptr = 1;

        // Round robin with all four requesting.
        req = 4'hF;
        for (int c = 0; c < 8; c++) begin
            int g;
            #1;
            check_val("rr_gnt", 32'(gnt), 32'd1 << exp_ptr);
            g = exp_ptr;
            tick();
            check_write("rr_wr", g);
            exp_ptr = (exp_ptr + 1) % 4;
        end
        req = 4'h0;

        // Filtering on requester 2.
        req = 4'b0100;
        set_req2(10'd3, 10'd4, 5'h15);
        #1; check_val("transp_gnt", 32'(gnt), 32'b0100);
        tick(); check_val("transp_we", 32'(fb_we), 32'd0);
        set_req2(10'd24, 10'd0, 5'h07);
        #1; check_val("xoor_gnt", 32'(gnt), 32'b0100);
        tick(); check_val("xoor_we", 32'(fb_we), 32'd0);
        set_req2(10'd0, 10'd45, 5'h07);
        tick(); check_val("yoor_we", 32'(fb_we), 32'd0);
        set_req2(10'd3, 10'd4, 5'h07);
        tick();
        check_val("valid_we",   32'(fb_we),    32'd1);
        check_val("valid_addr", 32'(fb_addr),  32'd99);
        check_val("valid_data", 32'(fb_wdata), 32'h07);
        set_req2(10'd23, 10'd44, 5'h09);
        tick();
        check_val("corner_we",   32'(fb_we),    32'd1);
        check_val("corner_addr", 32'(fb_addr),  32'd1079);
        check_val("corner_data", 32'(fb_wdata), 32'h09);
        req = 4'h0;
        set_req2(10'd3, 10'd4, 5'd3);
        exp_ptr = 3;

        // VS falls with only three drawers done: overrun, no swap.
        done = 4'b0111;
        tick(); tick();
        VS = 1'b0;
        tick();
        check_val("ovr_flag", 32'(overrun),     32'd1);
        check_val("ovr_bsel", 32'(buf_sel),     32'd0);
        check_val("ovr_fs",   32'(frame_start), 32'd0);
        VS = 1'b1;
        done = 4'hF;
        tick(); tick();
        done = 4'h0;
        req  = 4'hF;
        #1;
        check_val("wait_gnt", 32'(gnt), 32'd0);

        // Proper swap on the next VS falling edge.
        VS = 1'b0;
        #1;
        check_val("preswap_bsel", 32'(buf_sel), 32'd0);
        tick();
        check_val("swap_bsel", 32'(buf_sel),     32'd1);
        check_val("swap_fs",   32'(frame_start), 32'd1);
        check_val("swap_ovr",  32'(overrun),     32'd1);
        check_val("swap_gnt",  32'(gnt),         32'd0);
        VS = 1'b1;
        tick();
        check_val("post_fs",   32'(frame_start), 32'd0);
        check_val("post_bsel", 32'(buf_sel),     32'd1);
`ifdef ARB_CLEAR_EN
        check_val("post_gnt", 32'(gnt), 32'd0);
        tick();
        check_val("reclr_we",   32'(fb_we),   32'd1);
        check_val("reclr_addr", 32'(fb_addr), 32'd0);
        tick();
        check_val("reclr_addr1", 32'(fb_addr), 32'd1);
`else
        // Straight back to DRAW with done tracking cleared.
        check_val("post_gnt", 32'(gnt), 32'b1000);
        tick();
        check_write("post_wr3", 3);
        check_val("post_gnt2", 32'(gnt), 32'b0001);
        tick();
        check_write("post_wr0", 0);
`endif

        // Reset mid-frame drops the pending write.
        Reset = 1'b1;
        tick();
        check_val("mrst_we",   32'(fb_we),       32'd0);
        check_val("mrst_addr", 32'(fb_addr),     32'd0);
        check_val("mrst_bsel", 32'(buf_sel),     32'd0);
        check_val("mrst_ovr",  32'(overrun),     32'd0);
        check_val("mrst_gnt",  32'(gnt),         32'd0);
        Reset = 1'b0;
        req   = 4'h0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
